// File: rtl/mem_stage_pkg.sv
// Shared types, widths and access-size helpers for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned F3_W       = 3;

    localparam logic [F3_W-1:0] LB  = 3'b000;
    localparam logic [F3_W-1:0] LH  = 3'b001;
    localparam logic [F3_W-1:0] LW  = 3'b010;
    localparam logic [F3_W-1:0] LBU = 3'b100;
    localparam logic [F3_W-1:0] LHU = 3'b101;
    localparam logic [F3_W-1:0] SB  = 3'b000;
    localparam logic [F3_W-1:0] SH  = 3'b001;
    localparam logic [F3_W-1:0] SW  = 3'b010;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam logic [BE_W-1:0]   BE_ALL         = 4'b1111;
    localparam logic [ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Operation context held while the bus access is outstanding.
    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [ADDR_W-1:0]     pc;
        logic [F3_W-1:0]       funct3;
        logic [1:0]            addr_lo;
    } op_t;

    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
        case (size)
            SZ_B:    byte_enable = 4'b0001 << addr_lo;
            SZ_H:    byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = BE_ALL;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicate_store(input logic [1:0]        size,
                                                          input logic [DATA_W-1:0] data);
        case (size)
            SZ_B:    replicate_store = {4{data[7:0]}};
            SZ_H:    replicate_store = {2{data[15:0]}};
            default: replicate_store = data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = addr_lo[0];
            default: is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Lane extraction and sign/zero extension of a load response word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [F3_W-1:0]   funct3,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_c = rdata;
        case (funct3)
            LB:      data_c = {{24{byte_lane[7]}}, byte_lane};
            LH:      data_c = {{16{half_lane[15]}}, half_lane};
            LBU:     data_c = {24'h0, byte_lane};
            LHU:     data_c = {16'h0, half_lane};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the req/gnt/rvalid bus and registers write-back.
// Optional MEM_MISALIGN_CHECK_EN: misaligned H/W accesses skip the bus and raise misalign_o.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  reg_write_i,
    input  logic [F3_W-1:0]       funct3_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [ADDR_W-1:0]     pc_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    output logic [BE_W-1:0]       dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [ADDR_W-1:0]     pc_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    state_e            state;
    op_t               op;
    logic              mem_op_c;
    logic              misalign_c;
    logic [1:0]        access_size_c;
    logic [DATA_W-1:0] load_data_c;

    assign mem_op_c      = mem_read_i | mem_write_i;
    assign access_size_c = funct3_i[1:0];
    assign stall_o       = (state != ST_IDLE);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_c = is_misaligned(access_size_c, alu_result_i[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    load_align u_load_align (
        .rdata   (dmem_rdata_i),
        .addr_lo (op.addr_lo),
        .funct3  (op.funct3),
        .data_c  (load_data_c)
    );

    // Stores leave no write-back data; only loads and ALU ops update wb_data_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            op             <= '0;
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_addr_o    <= '0;
            dmem_wdata_o   <= '0;
            dmem_be_o      <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            pc_o           <= CPU_RESET_ADDR;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_o     <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        op <= '{reg_write: reg_write_i, rd: rd_i, pc: pc_i,
                                funct3: funct3_i, addr_lo: alu_result_i[1:0]};
                        if (mem_op_c && !misalign_c) begin
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_i;
                            dmem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
                            dmem_wdata_o <= replicate_store(access_size_c, store_data_i);
                            dmem_be_o    <= byte_enable(access_size_c, alu_result_i[1:0]);
                            state        <= ST_REQ;
                        end else begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_write_o <= reg_write_i & ~misalign_c;
                            wb_rd_o        <= rd_i;
                            wb_data_o      <= alu_result_i;
                            pc_o           <= pc_i;
`ifdef MEM_MISALIGN_CHECK_EN
                            misalign_o     <= misalign_c;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (dmem_we_o) begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_write_o <= 1'b0;
                            wb_rd_o        <= op.rd;
                            pc_o           <= op.pc;
                            state          <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o     <= 1'b1;
                        wb_reg_write_o <= op.reg_write;
                        wb_rd_o        <= op.rd;
                        wb_data_o      <= load_data_c;
                        pc_o           <= op.pc;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
